fifo_rr_arbiter: RTL

- Downstream consumer of the interconnect's input FIFOs, one FIFO per channel.
- Selects a non-empty source FIFO in round-robin order and issues its fifo_rd (pop).
- Captures the word the FIFO returns and writes it (fifo_wr / push) into one of the output FIFOs. The destination is chosen by the top DEST_W bits of the word.
- Honours the output FIFOs' almost_full flags as backpressure.

---
 rtl/fifo_rr_arbiter_pkg.sv | 26 ++
 rtl/fifo_rr_arbiter_rr_grant.sv | 43 ++++
 rtl/fifo_rr_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// rtl/fifo_rr_arbiter_pkg.sv - shared FSM encoding, default widths and one-hot helper for the FIFO arbiter
//
// Contents:
//   DEF_WORD_SIZE / DEF_DEST_W : default word and destination-field widths
//   arb_state_e                : arbiter FSM states (IDLE, ACTIVE, STALL)
//   onehot(dest)               : one-hot decode of a destination index (up to ONEHOT_W outputs)

package fifo_rr_arbiter_pkg;

    localparam int DEF_WORD_SIZE = 6;
    localparam int DEF_DEST_W    = 2;

    // Width of the onehot() result; callers cast it down to their channel count.
    localparam int ONEHOT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_STALL  = 2'b10
    } arb_state_e;

    function automatic logic [ONEHOT_W-1:0] onehot(input logic [ONEHOT_W-1:0] dest);
        return {{(ONEHOT_W-1){1'b0}}, 1'b1} << dest;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_grant.sv
// rtl/fifo_rr_arbiter_rr_grant.sv - combinational round-robin priority picker
//
// Ports:
//   req_i         : request vector, one bit per channel
//   rr_ptr_i      : channel with highest priority this cycle
//   grant_idx_o   : first requesting channel at or after rr_ptr_i (modulo NUM_CH)
//   grant_valid_o : high when any request is present

module rr_grant #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  rr_ptr_i,
    output logic [IDX_W-1:0]  grant_idx_o,
    output logic              grant_valid_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = 0;
        cand_idx      = '0;
        // Walk from the farthest candidate back toward rr_ptr_i so that the
        // candidate nearest the pointer overwrites any earlier hit. The
        // explicit wrap keeps this correct for non power-of-two channel counts.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_i) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                grant_idx_o   = cand_idx;
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin drain of per-channel input FIFOs into destination-addressed output FIFOs
//
// Ports:
//   clk            : system clock, all state on posedge
//   reset_L        : asynchronous active-low reset
//   fifo_empty_in  : empty flag of each source FIFO
//   data_in        : packed source read data, slice i = data_in[i*WORD_SIZE +: WORD_SIZE]
//   almost_full_in : almost_full of each destination FIFO (any bit stalls popping)
//   pop_out        : one-hot fifo_rd to the source FIFOs, registered
//   push_out       : one-hot fifo_wr to the destination FIFOs, registered
//   data_out       : write data shared by all destination FIFOs, registered
//   idle_out       : FSM idle with no word in flight, registered
//
// Pipeline: pop_out in cycle N, source data valid in N+1, push_out/data_out in N+2.

module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int DEST_W    = DEF_DEST_W,
    parameter int NUM_CH    = 4
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic [NUM_CH-1:0]           fifo_empty_in,
    input  logic [NUM_CH*WORD_SIZE-1:0] data_in,
    input  logic [NUM_CH-1:0]           almost_full_in,
    output logic [NUM_CH-1:0]           pop_out,
    output logic [NUM_CH-1:0]           push_out,
    output logic [WORD_SIZE-1:0]        data_out,
    output logic                        idle_out
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // FSM and round-robin pointer
    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Stage 1: pop issued this cycle (pop_out high), source answers next cycle
    logic             pop_v_q;
    logic [IDX_W-1:0] pop_idx_q;
    logic [NUM_CH-1:0] pop_q, pop_d;

    // Stage 2: source read data is on data_in for channel rd_idx_q
    logic             rd_v_q;
    logic [IDX_W-1:0] rd_idx_q;

    // Output registers
    logic [NUM_CH-1:0]    push_q, push_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 idle_q, idle_d;

    // Combinational helpers
    logic [NUM_CH-1:0]    req;
    logic                 any_req;
    logic                 stall;
    logic                 pop_fire;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic [WORD_SIZE-1:0] rd_word;
    logic [DEST_W-1:0]    rd_dest;

    assign req     = ~fifo_empty_in;
    assign any_req = |req;
    assign stall   = |almost_full_in;

    rr_grant #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_grant (
        .req_i         (req),
        .rr_ptr_i      (rr_ptr_q),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // Next-state logic. Every transition into ACTIVE requires req != 0 and no
    // almost_full, so the pop decision is simply "next state is ACTIVE"; this
    // lets a pop issue on the very edge that leaves IDLE or STALL and
    // suppresses a pop on the edge where almost_full first appears.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = stall ? ST_STALL : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (stall) begin
                    state_d = ST_STALL;
                end else if (!any_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (!any_req) begin
                    state_d = ST_IDLE;
                end else if (!stall) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop_fire = (state_d == ST_ACTIVE) && grant_valid;
        pop_d    = '0;
        rr_ptr_d = rr_ptr_q;
        if (pop_fire) begin
            pop_d = NUM_CH'(onehot(ONEHOT_W'(grant_idx)));
            if (grant_idx == IDX_W'(NUM_CH - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + IDX_W'(1);
            end
        end
    end

    // Pick the slice of the channel popped last cycle.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_idx_q == IDX_W'(i)) begin
                rd_word = data_in[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign rd_dest = rd_word[WORD_SIZE-1 -: DEST_W];

    always_comb begin
        push_d = '0;
        data_d = data_q;
        if (rd_v_q) begin
            push_d = NUM_CH'(onehot(ONEHOT_W'(rd_dest)));
            data_d = rd_word;
        end
        // Idle next cycle only if the FSM rests in IDLE and neither pipeline
        // stage will hold a word (stage 2 next cycle is stage 1 now).
        idle_d = (state_d == ST_IDLE) && !pop_fire && !pop_v_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            pop_q     <= '0;
            pop_v_q   <= 1'b0;
            pop_idx_q <= '0;
            rd_v_q    <= 1'b0;
            rd_idx_q  <= '0;
            push_q    <= '0;
            data_q    <= '0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            pop_q     <= pop_d;
            pop_v_q   <= pop_fire;
            pop_idx_q <= grant_idx;
            rd_v_q    <= pop_v_q;
            rd_idx_q  <= pop_idx_q;
            push_q    <= push_d;
            data_q    <= data_d;
            idle_q    <= idle_d;
        end
    end

    assign pop_out  = pop_q;
    assign push_out = push_q;
    assign data_out = data_q;
    assign idle_out = idle_q;

endmodule
